soc_system_sysid_checker: RTL
=============================

SOC_SYSTEM_SYSID_CHECKER -- requirements
Module: soc_system_sysid_checker

Interface
REQ-001 SHALL have parameter EXPECTED_ID, default 32'h0000_0000, system ID value the ID word must match.
REQ-002 SHALL have parameter EXPECTED_TS, default 32'h0000_0000, timestamp value the timestamp word must match.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, range 1..65535, max cycles allowed per word read.
REQ-004 SHALL have parameter AUTO_START, default 1, where 1 starts a check automatically after reset.
REQ-005 SHALL have port clock, input, 1, sole clock; all logic rising-edge.
REQ-006 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port start, input, 1, single-cycle request to re-run the check.
REQ-008 SHALL have port m_address, output, 1, sysid word select: 0 = ID, 1 = timestamp.
REQ-009 SHALL have port m_read, output, 1, Avalon-MM read strobe.
REQ-010 SHALL have port m_waitrequest, input, 1, slave stall; read accepted on a cycle with m_read=1, m_waitrequest=0.
REQ-011 SHALL have port m_readdatavalid, input, 1, m_readdata valid this cycle.
REQ-012 SHALL have port m_readdata, input, 32, read return data.
REQ-013 SHALL have ports id_value and ts_value, outputs, 32 each, captured ID and timestamp words.
REQ-014 SHALL have ports busy, done, id_ok, ts_ok and timeout, outputs, 1 each, registered status flags.

Function
REQ-015 SHALL implement FSM states IDLE, ID_REQ, ID_WAIT, TS_REQ, TS_WAIT, DONE.
REQ-016 SHALL leave reset in ID_REQ when AUTO_START=1, else in IDLE; first request on the first clock edge after reset_n rises.
REQ-017 SHALL in IDLE or DONE, on start=1, clear done/id_ok/ts_ok/timeout/id_value/ts_value and enter ID_REQ on the next cycle.
REQ-018 SHALL ignore start in ID_REQ, ID_WAIT, TS_REQ and TS_WAIT.
REQ-019 SHALL drive m_read=1, m_address=0 in ID_REQ and m_read=1, m_address=1 in TS_REQ, with m_read=0 and m_address=0 in all other states.
REQ-020 SHALL hold m_read and m_address stable while m_waitrequest=1, moving ID_REQ->ID_WAIT or TS_REQ->TS_WAIT on the acceptance cycle.
REQ-021 SHALL ignore m_readdatavalid outside ID_WAIT and TS_WAIT.
REQ-022 SHALL in ID_WAIT, on m_readdatavalid=1, load id_value, set id_ok=(m_readdata==EXPECTED_ID), enter TS_REQ.
REQ-023 SHALL in TS_WAIT, on m_readdatavalid=1, load ts_value, set ts_ok=(m_readdata==EXPECTED_TS), enter DONE.
REQ-024 SHALL keep a 16-bit timeout counter cleared on entry to ID_REQ and TS_REQ, incrementing each cycle in REQ/WAIT states.
REQ-025 SHALL, when the counter reaches TIMEOUT_CYCLES before the word completes, set timeout=1, deassert m_read that cycle's successor and enter DONE; unread words keep value 0 and ok flag 0.
REQ-026 SHALL take readdatavalid over timeout when both occur on the same cycle.
REQ-027 SHALL drive busy=1 in the four REQ/WAIT states, done=1 only in DONE.
REQ-028 SHALL give a zero-wait, one-cycle-latency slave a total check time of 4 cycles from ID_REQ entry to DONE.

Reset
REQ-029 SHALL on reset_n=0 immediately force m_read=0, m_address=0, busy=0, done=0, id_ok=0, ts_ok=0, timeout=0, id_value=0, ts_value=0, counter=0, state IDLE.
REQ-030 SHALL abort any in-flight transaction on reset mid-operation and discard any later readdatavalid.

Verification
REQ-031 SHALL verify: AUTO_START=1, slave no-wait latency 1, returns matching words -> done=1 at cycle 4, id_ok=1, ts_ok=1, timeout=0.
REQ-032 SHALL verify: m_waitrequest=1 for 3 cycles on ID read -> m_read/m_address=0 held 4 cycles, then normal completion.
REQ-033 SHALL verify: ID word returns EXPECTED_ID^1 -> id_value captured, id_ok=0, ts_ok=1, done=1.
REQ-034 SHALL verify: TIMEOUT_CYCLES=8, no readdatavalid on TS read -> timeout=1, done=1, ts_value=0, ts_ok=0, m_read=0.
REQ-035 SHALL verify: start pulsed while busy ignored; start in DONE clears flags and reruns the check with identical results.
REQ-036 SHALL verify: reset_n asserted during ID_WAIT -> all outputs 0 asynchronously, late readdatavalid ignored, check restarts per AUTO_START.

Source files
------------

// File: rtl/soc_system_sysid_checker_if.sv
// Avalon-MM read-only master bundle used to poll a sysid peripheral.
// The master drives address/read; the slave drives the stall and return path.
interface soc_system_sysid_checker_if;
  logic        m_address;
  logic        m_read;
  logic        m_waitrequest;
  logic        m_readdatavalid;
  logic [31:0] m_readdata;

  modport master (
    output m_address,
    output m_read,
    input  m_waitrequest,
    input  m_readdatavalid,
    input  m_readdata
  );

  modport slave (
    input  m_address,
    input  m_read,
    output m_waitrequest,
    output m_readdatavalid,
    output m_readdata
  );
endinterface

// File: rtl/soc_system_sysid_checker.sv
// Reads the sysid ID and timestamp words over Avalon-MM and compares them with the
// build-time values, with a per-word timeout so a dead slave cannot hang the check.
module soc_system_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TS    = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic                              clock,
  input  logic                              reset_n,
  input  logic                              start,
  soc_system_sysid_checker_if.master        bus,
  output logic [31:0]                       id_value,
  output logic [31:0]                       ts_value,
  output logic                              busy,
  output logic                              done,
  output logic                              id_ok,
  output logic                              ts_ok,
  output logic                              timeout
);

  localparam logic [15:0] TimeoutLimit = 16'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    StIdle,
    StIdReq,
    StIdWait,
    StTsReq,
    StTsWait,
    StDone
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        armed_q, armed_d;
  logic        clear_results;
  logic        capture_id;
  logic        capture_ts;
  logic        set_timeout;
  logic        expired;
  logic        entering_req;

  // The counter value equals the number of cycles already spent on the current word.
  assign expired = (cnt_q >= TimeoutLimit);

  always_comb begin
    state_d       = state_q;
    armed_d       = armed_q;
    clear_results = 1'b0;
    capture_id    = 1'b0;
    capture_ts    = 1'b0;
    set_timeout   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start || armed_q) begin
          state_d       = StIdReq;
          armed_d       = 1'b0;
          clear_results = 1'b1;
        end
      end
      StDone: begin
        if (start) begin
          state_d       = StIdReq;
          clear_results = 1'b1;
        end
      end
      StIdReq: begin
        if (expired) begin
          state_d     = StDone;
          set_timeout = 1'b1;
        end else if (!bus.m_waitrequest) begin
          state_d = StIdWait;
        end
      end
      StIdWait: begin
        // Returned data wins over a timeout landing on the same cycle.
        if (bus.m_readdatavalid) begin
          state_d    = StTsReq;
          capture_id = 1'b1;
        end else if (expired) begin
          state_d     = StDone;
          set_timeout = 1'b1;
        end
      end
      StTsReq: begin
        if (expired) begin
          state_d     = StDone;
          set_timeout = 1'b1;
        end else if (!bus.m_waitrequest) begin
          state_d = StTsWait;
        end
      end
      StTsWait: begin
        if (bus.m_readdatavalid) begin
          state_d    = StDone;
          capture_ts = 1'b1;
        end else if (expired) begin
          state_d     = StDone;
          set_timeout = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign entering_req = ((state_d == StIdReq) && (state_q != StIdReq)) ||
                        ((state_d == StTsReq) && (state_q != StTsReq));

  always_comb begin
    cnt_d = cnt_q;
    if (entering_req) begin
      cnt_d = 16'd0;
    end else if ((state_q == StIdReq) || (state_q == StIdWait) ||
                 (state_q == StTsReq) || (state_q == StTsWait)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      cnt_q         <= 16'd0;
      armed_q       <= AUTO_START;
      bus.m_read    <= 1'b0;
      bus.m_address <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      id_ok         <= 1'b0;
      ts_ok         <= 1'b0;
      timeout       <= 1'b0;
      id_value      <= 32'd0;
      ts_value      <= 32'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      armed_q       <= armed_d;
      bus.m_read    <= (state_d == StIdReq) || (state_d == StTsReq);
      bus.m_address <= (state_d == StTsReq);
      busy          <= (state_d == StIdReq) || (state_d == StIdWait) ||
                       (state_d == StTsReq) || (state_d == StTsWait);
      done          <= (state_d == StDone);

      if (clear_results) begin
        id_ok    <= 1'b0;
        ts_ok    <= 1'b0;
        timeout  <= 1'b0;
        id_value <= 32'd0;
        ts_value <= 32'd0;
      end
      if (capture_id) begin
        id_value <= bus.m_readdata;
        id_ok    <= (bus.m_readdata == EXPECTED_ID);
      end
      if (capture_ts) begin
        ts_value <= bus.m_readdata;
        ts_ok    <= (bus.m_readdata == EXPECTED_TS);
      end
      if (set_timeout) begin
        timeout <= 1'b1;
      end
    end
  end

endmodule
